// File: rtl/status_reg.sv
// 6502-style processor status register: delayed ALU flag updates, direct flag
// writes, PLP/RTI loads and registered branch evaluation against the next P value.
module status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic [2:0] flag_op,
  input  logic       load_p,
  input  logic       irq_set_i,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [7:0] db_in,
  input  logic       br_eval,
  input  logic [2:0] br_cond,
  input  logic       brk_flag,
  output logic [7:0] p,
  output logic [7:0] p_push,
  output logic       dec_mode,
  output logic       br_valid,
  output logic       br_taken
);

  localparam logic [7:0] P_RESET = 8'h34;

  logic [7:0] p_reg, p_next;
  logic       pend_nz_reg, pend_c_reg, pend_v_reg, pend_bit_reg;
  logic [1:0] pend_m_reg;
  logic       br_valid_reg, br_taken_reg;
  logic       br_taken_next;
  logic       alu_zero;
  logic       flag_sel;

  // Lowest to highest priority: pending ALU update, then direct writes, then load.
  always_comb begin
    alu_zero = (alu_out == 8'h00);
    p_next   = p_reg;
    if (pend_nz_reg) begin
      p_next[7] = alu_out[7];
      p_next[1] = alu_zero;
    end
    if (pend_c_reg) p_next[0] = alu_c;
    if (pend_v_reg) p_next[6] = alu_v;
    if (pend_bit_reg) begin
      p_next[7] = pend_m_reg[1];
      p_next[6] = pend_m_reg[0];
      p_next[1] = alu_zero;
    end
    case (flag_op)
      3'b001:  p_next[0] = 1'b0;
      3'b010:  p_next[0] = 1'b1;
      3'b011:  p_next[2] = 1'b0;
      3'b100:  p_next[2] = 1'b1;
      3'b101:  p_next[6] = 1'b0;
      3'b110:  p_next[3] = 1'b0;
      3'b111:  p_next[3] = 1'b1;
      default: ;
    endcase
    if (irq_set_i) p_next[2] = 1'b1;
    if (load_p)    p_next = db_in;
    p_next[5:4] = 2'b11;
  end

  // Branch tests the flag value P will hold after this edge.
  always_comb begin
    case (br_cond[2:1])
      2'b00:   flag_sel = p_next[7];
      2'b01:   flag_sel = p_next[6];
      2'b10:   flag_sel = p_next[0];
      default: flag_sel = p_next[1];
    endcase
    br_taken_next = (flag_sel == br_cond[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg        <= P_RESET;
      pend_nz_reg  <= 1'b0;
      pend_c_reg   <= 1'b0;
      pend_v_reg   <= 1'b0;
      pend_bit_reg <= 1'b0;
      pend_m_reg   <= 2'b00;
      br_valid_reg <= 1'b0;
      br_taken_reg <= 1'b0;
    end else begin
      p_reg        <= p_next;
      pend_nz_reg  <= upd_nz;
      pend_c_reg   <= upd_c;
      pend_v_reg   <= upd_v;
      pend_bit_reg <= bit_op;
      pend_m_reg   <= db_in[7:6];
      br_valid_reg <= br_eval;
      if (br_eval) br_taken_reg <= br_taken_next;
    end
  end

  assign p        = p_reg;
  assign p_push   = {p_reg[7:6], 1'b1, brk_flag, p_reg[3:0]};
  assign dec_mode = p_reg[3];
  assign br_valid = br_valid_reg;
  assign br_taken = br_taken_reg;

endmodule

// File: tb/tb_status_reg.sv
// Table-driven bench for status_reg: each row is one clock of stimulus plus the
// expected registered state after that edge, checked through a scoreboard queue.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_nz, upd_c, upd_v, bit_op;
  logic [2:0] flag_op;
  logic       load_p, irq_set_i;
  logic [7:0] alu_out;
  logic       alu_c, alu_v;
  logic [7:0] db_in;
  logic       br_eval;
  logic [2:0] br_cond;
  logic       brk_flag;
  logic [7:0] p, p_push;
  logic       dec_mode, br_valid, br_taken;

  always #5 clk = ~clk;

  status_reg dut (
    .clk(clk), .rst(rst),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op),
    .flag_op(flag_op), .load_p(load_p), .irq_set_i(irq_set_i),
    .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v), .db_in(db_in),
    .br_eval(br_eval), .br_cond(br_cond), .brk_flag(brk_flag),
    .p(p), .p_push(p_push), .dec_mode(dec_mode),
    .br_valid(br_valid), .br_taken(br_taken)
  );

  // upd = {nz, c, v, bit}; cv = {alu_c, alu_v}
  typedef struct {
    logic       rst;
    logic [3:0] upd;
    logic [2:0] flag;
    logic       load;
    logic       irq;
    logic [7:0] alu;
    logic [1:0] cv;
    logic [7:0] db;
    logic       bre;
    logic [2:0] brc;
    logic       brk;
    logic [7:0] exp_p;
    logic       exp_bv;
    logic       exp_bt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] p;
    logic [7:0] push;
    logic       dm;
    logic       bv;
    logic       bt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = v.rst; {upd_nz, upd_c, upd_v, bit_op} = v.upd;
    flag_op = v.flag; load_p = v.load; irq_set_i = v.irq;
    alu_out = v.alu; {alu_c, alu_v} = v.cv; db_in = v.db;
    br_eval = v.bre; br_cond = v.brc; brk_flag = v.brk;
    e.idx = idx; e.p = v.exp_p; e.dm = v.exp_p[3]; e.bv = v.exp_bv; e.bt = v.exp_bt;
    e.push = {v.exp_p[7:6], 1'b1, v.brk, v.exp_p[3:0]};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_vec++;
    if (p !== got.p || p_push !== got.push || dec_mode !== got.dm ||
        br_valid !== got.bv || br_taken !== got.bt) begin
      n_err++;
      $display("FAIL vec%0d: p=%h push=%h dm=%b bv=%b bt=%b, required p=%h push=%h dm=%b bv=%b bt=%b",
               got.idx, p, p_push, dec_mode, br_valid, br_taken,
               got.p, got.push, got.dm, got.bv, got.bt);
    end else begin
      $display("vec%0d ok: p=%h bv=%b bt=%b", got.idx, p, br_valid, br_taken);
    end
  endtask

  initial begin
    rst = 1'b1; {upd_nz, upd_c, upd_v, bit_op} = '0; flag_op = '0; load_p = 0;
    irq_set_i = 0; alu_out = '0; {alu_c, alu_v} = '0; db_in = '0;
    br_eval = 0; br_cond = '0; brk_flag = 0;

    //            rst upd     flag  ld irq alu    cv     db     bre brc   brk exp_p  bv bt
    vecs.push_back('{1, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // reset
    vecs.push_back('{1, 4'b0100, 3'd2, 1, 1, 8'h00, 2'b00, 8'hFF, 1, 3'd7, 0, 8'h34, 0, 0}); // reset beats all
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b10, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // nothing lands
    vecs.push_back('{0, 4'b1100, 3'd0, 0, 0, 8'h80, 2'b00, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // issue nz+c
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b10, 8'h00, 0, 3'd0, 0, 8'h37, 0, 0}); // Z=1 C=1 N=0
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h80, 2'b00, 8'h00, 0, 3'd0, 1, 8'h37, 0, 0}); // expired
    vecs.push_back('{0, 4'b0100, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h37, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd2, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h37, 0, 0}); // SEC beats C=0
    vecs.push_back('{0, 4'b1100, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h37, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd0, 1, 0, 8'h80, 2'b10, 8'h00, 0, 3'd0, 0, 8'h30, 0, 0}); // load beats pend
    vecs.push_back('{0, 4'b1000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h30, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 1, 3'd7, 0, 8'h32, 1, 1}); // BEQ forwarded
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 1, 3'd6, 0, 8'h32, 1, 0}); // BNE
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h32, 0, 0});
    vecs.push_back('{0, 4'b0001, 3'd0, 0, 0, 8'h00, 2'b00, 8'hC0, 0, 3'd0, 0, 8'h32, 0, 0}); // BIT issue
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 1, 3'd1, 0, 8'hF2, 1, 1}); // N V Z, BMI
    vecs.push_back('{0, 4'b1011, 3'd0, 0, 0, 8'h00, 2'b00, 8'h40, 0, 3'd0, 0, 8'hF2, 0, 1}); // BIT+nz+v
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h80, 2'b00, 8'h00, 1, 3'd3, 0, 8'h70, 1, 1}); // BIT wins, BVS
    vecs.push_back('{0, 4'b0000, 3'd7, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h78, 0, 1}); // SED
    vecs.push_back('{0, 4'b0000, 3'd4, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h7C, 0, 1}); // SEI
    vecs.push_back('{0, 4'b0000, 3'd3, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h78, 0, 1}); // CLI
    vecs.push_back('{0, 4'b0000, 3'd5, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h38, 0, 1}); // CLV
    vecs.push_back('{0, 4'b0000, 3'd6, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h30, 0, 1}); // CLD
    vecs.push_back('{0, 4'b0000, 3'd2, 0, 0, 8'h00, 2'b00, 8'h00, 1, 3'd5, 0, 8'h31, 1, 1}); // SEC, BCS
    vecs.push_back('{0, 4'b0000, 3'd1, 0, 0, 8'h00, 2'b00, 8'h00, 1, 3'd5, 0, 8'h30, 1, 0}); // CLC, BCS
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 1, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // irq sets I
    vecs.push_back('{0, 4'b0010, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd5, 0, 0, 8'h00, 2'b01, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // CLV beats V=1
    vecs.push_back('{0, 4'b0010, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b01, 8'h00, 1, 3'd2, 0, 8'h74, 1, 0}); // V=1, BVC
    vecs.push_back('{0, 4'b0000, 3'd0, 1, 0, 8'h00, 2'b00, 8'hFF, 0, 3'd0, 0, 8'hFF, 0, 0}); // PLP FF
    vecs.push_back('{0, 4'b0000, 3'd0, 1, 1, 8'h00, 2'b00, 8'h00, 1, 3'd0, 0, 8'h30, 1, 1}); // load beats irq, BPL
    vecs.push_back('{0, 4'b0100, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h30, 0, 1}); // issue C
    vecs.push_back('{1, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b10, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // reset mid-op
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b10, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0});
    vecs.push_back('{0, 4'b1000, 3'd0, 0, 0, 8'h11, 2'b00, 8'h00, 0, 3'd0, 0, 8'h34, 0, 0}); // back-to-back nz
    vecs.push_back('{0, 4'b1000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'h36, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h80, 2'b00, 8'h00, 0, 3'd0, 0, 8'hB4, 0, 0});
    vecs.push_back('{0, 4'b0000, 3'd0, 0, 0, 8'h00, 2'b00, 8'h00, 0, 3'd0, 0, 8'hB4, 0, 0});

    foreach (vecs[i]) apply(vecs[i], i);

    // p_push follows brk_flag combinationally with no clock edge.
    @(negedge clk);
    brk_flag = 1'b0;
    #1;
    n_vec++;
    if (p_push !== 8'hA4) begin
      n_err++;
      $display("FAIL push_brk0: p_push=%h, required %h", p_push, 8'hA4);
    end else $display("push_brk0 ok: p_push=%h", p_push);
    brk_flag = 1'b1;
    #1;
    n_vec++;
    if (p_push !== 8'hB4) begin
      n_err++;
      $display("FAIL push_brk1: p_push=%h, required %h", p_push, 8'hB4);
    end else $display("push_brk1 ok: p_push=%h", p_push);

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 upd_nz  in  1  issue-cycle request: N/Z take the ALU result one cycle later.
REQ-004 upd_c  in  1  issue-cycle request: C takes alu_c one cycle later.
REQ-005 upd_v  in  1  issue-cycle request: V takes alu_v one cycle later.
REQ-006 bit_op  in  1  issue-cycle BIT request: N,V from db_in[7:6] captured now; Z from (alu_out==0) one cycle later.
REQ-007 flag_op  in  3  direct flag write: 000 none, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLV, 110 CLD, 111 SED.
REQ-008 load_p  in  1  load P from db_in (PLP/RTI).
REQ-009 irq_set_i  in  1  set I (interrupt/BRK entry).
REQ-010 alu_out  in  8  ALU result; valid the cycle after issue.
REQ-011 alu_c, alu_v  in  1 each  ALU carry/overflow; valid the cycle after issue.
REQ-012 db_in  in  8  data bus byte (PLP source, BIT operand).
REQ-013 br_eval  in  1  request branch evaluation.
REQ-014 br_cond  in  3  6502 branch opcode bits[7:5]: 000 BPL, 001 BMI, 010 BVC, 011 BVS, 100 BCC, 101 BCS, 110 BNE, 111 BEQ.
REQ-015 brk_flag  in  1  B value for pushed status byte.
REQ-016 p  out  8  status {N,V,1,1,D,I,Z,C}, registered.
REQ-017 p_push  out  8  {N,V,1,brk_flag,D,I,Z,C}, combinational from p.
REQ-018 dec_mode  out  1  equals p[3].
REQ-019 br_valid  out  1  registered; high one cycle after br_eval.
REQ-020 br_taken  out  1  registered branch result, meaningful when br_valid=1.

Function
REQ-021 Block SHALL hold a pending-update register {pend_nz, pend_c, pend_v, pend_bit, pend_m[1:0]} loaded every edge from upd_nz/upd_c/upd_v/bit_op and db_in[7:6].
REQ-022 Pending updates SHALL apply at the edge after issue (latency 1), then expire unless re-issued; back-to-back issues SHALL pipeline with no stall.
REQ-023 pend_nz SHALL set N=alu_out[7], Z=(alu_out==8'h00).
REQ-024 pend_bit SHALL set N=pend_m[1], V=pend_m[0], Z=(alu_out==8'h00); pend_bit with pend_nz or pend_v SHALL give pend_bit precedence on N/V/Z.
REQ-025 pend_c SHALL set C=alu_c; pend_v SHALL set V=alu_v.
REQ-026 flag_op SHALL modify only its named bit at the next edge.
REQ-027 irq_set_i SHALL set I=1 at the next edge.
REQ-028 Per-bit priority at one edge: load_p > flag_op/irq_set_i > pending update > hold.
REQ-029 load_p SHALL load p[7:6] and p[3:0] from db_in; db_in[5:4] ignored.
REQ-030 p[5] and p[4] SHALL always read 1.
REQ-031 Combinational p_next (value p takes at next edge) SHALL be formed by REQ-023..REQ-030.
REQ-032 On br_eval, br_taken SHALL register cond(br_cond, p_next), forwarding a pending update landing that edge; odd codes test flag=1, even codes flag=0; flag: 00x N, 01x V, 10x C, 11x Z.
REQ-033 br_valid SHALL register br_eval; br_taken SHALL hold its value when br_eval=0.

Reset
REQ-034 rst SHALL set p=8'h34 (I=1, bits 5/4=1, others 0), clear all pending state, br_valid=0, br_taken=0.
REQ-035 rst SHALL override all simultaneous inputs; pending updates issued in the reset cycle SHALL be discarded, and nothing SHALL apply in the cycle after reset.

Verification
REQ-036 Reset: rst 1 cycle -> p=8'h34, br_valid=0, br_taken=0.
REQ-037 Pending: upd_nz=upd_c=1 at N; alu_out=8'h00, alu_c=1 at N+1 -> after N+1 edge p[1]=1, p[0]=1, p[7]=0; p unchanged after N edge.
REQ-038 Priority: pending C=0 landing same edge as flag_op=010 (SEC) -> C=1; same edge with load_p, db_in=8'h00 -> p=8'h30.
REQ-039 Forwarding: upd_nz at N (alu_out=8'h00 at N+1), br_eval br_cond=111 at N+1 -> br_valid=1, br_taken=1 after N+1 edge.
REQ-040 BIT: bit_op with db_in=8'hC0 at N; alu_out=8'h00 at N+1 -> N=1, V=1, Z=1.
REQ-041 Reset mid-operation: upd_c at N, rst at N+1 with alu_c=1 -> p=8'h34, C=0.
